// File: rtl/dram_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU load/store path
// and the read-only video fetch path. The CPU has priority. A starvation
// counter forces a video slot after MAX_WAIT consecutive denied cycles.
//
// owner_q states:
//   state      | meaning
//   OWN_NONE   | no read in flight (idle, CPU write, or reset)
//   OWN_CPU_RD | CPU read issued last cycle, mem_rdata belongs to CPU
//   OWN_VID_RD | video read issued last cycle, mem_rdata belongs to video
module dram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_VID_RD = 2'd2
    } owner_t;

    owner_t             owner_q;
    owner_t             owner_d;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic               cpu_grant;
    logic               vid_grant;
    logic               starved;

    assign starved = (wait_cnt == CNT_W'(MAX_WAIT));

    // Grant decision, memory port mux and next owner / counter values.
    // Nothing is granted while rst is high so no write can slip through.
    always_comb begin
        cpu_grant  = 1'b0;
        vid_grant  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        owner_d    = OWN_NONE;
        wait_cnt_d = wait_cnt;

        if (!rst) begin
            if (vid_req && (starved || !cpu_req)) begin
                vid_grant = 1'b1;
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end
        end

        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            owner_d   = cpu_we ? OWN_NONE : OWN_CPU_RD;
        end else if (vid_grant) begin
            mem_addr  = vid_addr;
            owner_d   = OWN_VID_RD;
        end

        if (vid_grant || !vid_req) begin
            wait_cnt_d = '0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt + 1'b1;
        end
    end

    // Owner tag and starvation counter registers; reset drops any return.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            wait_cnt <= '0;
        end else begin
            owner_q  <= owner_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_grant;
    assign vid_gnt    = vid_grant;
    assign cpu_rvalid = (owner_q == OWN_CPU_RD);
    assign vid_rvalid = (owner_q == OWN_VID_RD);
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter with a behavioural single-port RAM.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        vid_req;
    logic [9:0]  vid_addr;
    logic        vid_gnt;
    logic [31:0] vid_rdata;
    logic        vid_rvalid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] ram [0:1023];

    int checks = 0;
    int errors = 0;

    dram_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM: registered read, write visible to the next access
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        rst, creq, cwe;
        logic [9:0]  caddr;
        logic [31:0] cwd;
        logic        vreq;
        logic [9:0]  vaddr;
        logic        stall, vgnt, mwe;
        logic [9:0]  maddr;
        logic        crv, vrv;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic cq, logic cw, logic [9:0] ca, logic [31:0] cd,
                                logic vq, logic [9:0] va, logic st, logic vg, logic mw,
                                logic [9:0] ma, logic crv, logic vrv, logic [31:0] rd);
        vec_t v;
        v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.vreq = vq; v.vaddr = va; v.stall = st; v.vgnt = vg; v.mwe = mw;
        v.maddr = ma; v.crv = crv; v.vrv = vrv; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic cq, input logic cw, input logic [9:0] ca,
                         input logic [31:0] cd, input logic vq, input logic [9:0] va);
        @(negedge clk);
        rst = r; cpu_req = cq; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        vid_req = vq; vid_addr = va;
        #4;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // preload RAM while the arbiter is held in reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_en = 1'b1;
            case (i)
                0: begin ld_addr = 10'h010; ld_data = 32'hDEADBEEF; end
                1: begin ld_addr = 10'h001; ld_data = 32'hA0000001; end
                2: begin ld_addr = 10'h002; ld_data = 32'hB0000002; end
                default: begin ld_addr = 10'h003; ld_data = 32'hC0000003; end
            endcase
        end
        @(negedge clk);
        ld_en = 1'b0;

        //              rst cq cw caddr   cwdata        vq vaddr   st vg mw maddr   crv vrv rdata
        vecs.push_back(mk(1, 1, 1, 10'h010, 32'h55AA55AA, 1, 10'h020, 1, 0, 0, 10'h000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 10'h010, 32'h55AA55AA, 1, 10'h020, 1, 0, 0, 10'h000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 10'h010, 32'h55AA55AA, 1, 10'h020, 1, 0, 0, 10'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 10'h030, 32'hFFFFFFFF, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h010, 32'h00000000, 0, 10'h000, 0, 0, 0, 10'h010, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 10'h000, 32'h00000000, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 10'h020, 32'h12345678, 0, 10'h000, 0, 0, 1, 10'h020, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 10'h000, 32'h00000000, 1, 10'h020, 0, 1, 0, 10'h020, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 10'h000, 32'h00000000, 0, 10'h000, 0, 0, 0, 10'h000, 0, 1, 32'h12345678));
        vecs.push_back(mk(0, 1, 0, 10'h001, 32'h00000000, 0, 10'h000, 0, 0, 0, 10'h001, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 10'h000, 32'h00000000, 1, 10'h002, 0, 1, 0, 10'h002, 1, 0, 32'hA0000001));
        vecs.push_back(mk(0, 1, 0, 10'h003, 32'h00000000, 0, 10'h000, 0, 0, 0, 10'h003, 0, 1, 32'hB0000002));
        vecs.push_back(mk(0, 0, 0, 10'h000, 32'h00000000, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 32'hC0000003));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].vreq, vecs[i].vaddr);
            chk($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
            chk($sformatf("vec%0d vid_gnt", i), 32'(vid_gnt), 32'(vecs[i].vgnt));
            chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
            chk($sformatf("vec%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].crv));
            chk($sformatf("vec%0d vid_rvalid", i), 32'(vid_rvalid), 32'(vecs[i].vrv));
            if (vecs[i].mwe)
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].cwd);
            else if (!vecs[i].vgnt && (!vecs[i].creq || vecs[i].stall))
                chk($sformatf("vec%0d idle mem_wdata", i), mem_wdata, 32'h0);
            if (vecs[i].crv) chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vecs[i].rdata);
            if (vecs[i].vrv) chk($sformatf("vec%0d vid_rdata", i), vid_rdata, vecs[i].rdata);
        end

        // continuous contention: video wins every fifth cycle
        for (int k = 0; k < 15; k++) begin
            drive(0, 1, 0, 10'h001, 32'h0, 1, 10'h002);
            chk($sformatf("starve%0d vid_gnt", k), 32'(vid_gnt), 32'((k % 5) == 4));
            chk($sformatf("starve%0d cpu_stall", k), 32'(cpu_stall), 32'((k % 5) == 4));
            chk($sformatf("starve%0d mem_addr", k), 32'(mem_addr),
                ((k % 5) == 4) ? 32'h002 : 32'h001);
            if (k > 0) begin
                chk($sformatf("starve%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(((k - 1) % 5) != 4));
                chk($sformatf("starve%0d vid_rvalid", k), 32'(vid_rvalid), 32'(((k - 1) % 5) == 4));
                if (((k - 1) % 5) == 4) chk($sformatf("starve%0d vid_rdata", k), vid_rdata, 32'hB0000002);
                else                    chk($sformatf("starve%0d cpu_rdata", k), cpu_rdata, 32'hA0000001);
            end
        end

        // reset in the middle of contention with a read outstanding
        drive(0, 1, 0, 10'h001, 32'h0, 1, 10'h002);
        drive(0, 1, 0, 10'h001, 32'h0, 1, 10'h002);
        chk("pre_rst cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        drive(1, 1, 0, 10'h001, 32'h0, 1, 10'h002);
        chk("in_rst cpu_stall", 32'(cpu_stall), 32'h1);
        chk("in_rst vid_gnt", 32'(vid_gnt), 32'h0);
        chk("in_rst mem_we", 32'(mem_we), 32'h0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 10'h001, 32'h0, 1, 10'h002);
            if (k == 0) begin
                chk("post_rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
                chk("post_rst vid_rvalid", 32'(vid_rvalid), 32'h0);
            end
            chk($sformatf("post_rst%0d vid_gnt", k), 32'(vid_gnt), 32'(k == 4));
            chk($sformatf("post_rst%0d cpu_stall", k), 32'(cpu_stall), 32'(k == 4));
        end

        drive(0, 0, 0, 10'h0, 32'h0, 0, 10'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
